// File: rtl/softex_tcdm_responder_if.sv
// softex_tcdm_responder_if: HCI-core TCDM request/response bus between the streamer
// initiator (master) and a memory responder (slave).
interface softex_tcdm_responder_if #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 32,
   parameter int unsigned IW = 8
);
   logic            req;
   logic            gnt;
   logic [AW-1:0]   add;
   logic            wen;
   logic [DW/8-1:0] be;
   logic [DW-1:0]   data;
   logic [IW-1:0]   id;
   logic            r_valid;
   logic            r_ready;
   logic [DW-1:0]   r_data;
   logic [IW-1:0]   r_id;
   logic            r_opc;

   modport master (
      output req, add, wen, be, data, id, r_ready,
      input  gnt, r_valid, r_data, r_id, r_opc
   );

   modport slave (
      input  req, add, wen, be, data, id, r_ready,
      output gnt, r_valid, r_data, r_id, r_opc
   );
endinterface

// File: rtl/softex_tcdm_responder.sv
// softex_tcdm_responder: TCDM target backed by a word memory, fixed-latency in-order
// responses with ID echo, response backpressure and optional LFSR grant stalls.
module softex_tcdm_responder #(
   parameter int unsigned DW         = 32,
   parameter int unsigned AW         = 32,
   parameter int unsigned IW         = 8,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned LATENCY    = 1,
   parameter int unsigned RESP_DEPTH = 4,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                clear_i,
   input  logic                                stall_en_i,
   softex_tcdm_responder_if.slave              tcdm,
   output logic [$clog2(RESP_DEPTH+1)-1:0]     outstanding_o
);
   localparam int unsigned BW = DW / 8;
   localparam int unsigned BO = $clog2(BW);
   localparam int unsigned XW = $clog2(DEPTH);
   localparam int unsigned OW = $clog2(RESP_DEPTH + 1);
   localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int unsigned RW = DW + IW + 1;
   localparam logic [OW-1:0] RD   = OW'(RESP_DEPTH);
   localparam logic [PW-1:0] PMAX = PW'(RESP_DEPTH - 1);

   if (LATENCY < 1 || LATENCY > RESP_DEPTH) begin : g_bad_cfg
      $error("softex_tcdm_responder: need 1 <= LATENCY <= RESP_DEPTH");
   end

   logic [DW-1:0]      r_mem [DEPTH];
   logic [RW-1:0]      r_fifo [RESP_DEPTH];
   logic [RW-1:0]      r_pd [LATENCY];
   logic [LATENCY-1:0] r_pv;
   logic [15:0]        r_lfsr;
   logic [PW-1:0]      r_fi, r_fo;
   logic [OW-1:0]      r_fcnt, r_outst;

   logic [RW-1:0]      w_pd_n [LATENCY];
   logic [LATENCY-1:0] w_pv_n;
   logic [15:0]        w_lfsr_n;
   logic [PW-1:0]      w_fi_n, w_fo_n;
   logic [OW-1:0]      w_fcnt_n, w_outst_n;
   logic [XW-1:0]      w_idx;
   logic [RW-1:0]      w_head;
   logic               w_gnt, w_pop, w_fe, w_push, w_fpop, w_unused;

   // Address bits outside the word index are deliberately ignored (wrap, aligned only).
   assign w_unused = ^tcdm.add;
   assign w_idx    = tcdm.add[BO +: XW];
   assign w_gnt    = tcdm.req && (r_outst < RD) && !(stall_en_i && r_lfsr[0]);
   assign w_fe     = r_fcnt == '0;

   // The last pipe stage bypasses an empty FIFO so the first response costs exactly LATENCY.
   assign w_head   = w_fe ? r_pd[LATENCY-1] : r_fifo[r_fo];
   assign w_pop    = tcdm.r_valid && tcdm.r_ready;
   assign w_fpop   = w_pop && !w_fe;
   assign w_push   = r_pv[LATENCY-1] && !(w_pop && w_fe);

   assign tcdm.gnt     = w_gnt;
   assign tcdm.r_valid = !w_fe || r_pv[LATENCY-1];
   assign {tcdm.r_opc, tcdm.r_id, tcdm.r_data} = w_head;
   assign outstanding_o = r_outst;

   always_comb begin
      w_lfsr_n  = stall_en_i ? {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]} : r_lfsr;
      w_pv_n[0] = w_gnt;
      w_pd_n[0] = w_gnt ? {!tcdm.wen, tcdm.id, tcdm.wen ? r_mem[w_idx] : {DW{1'b0}}} : '0;
      for (int i = 1; i < LATENCY; i++) begin
         w_pv_n[i] = r_pv[i-1];
         w_pd_n[i] = r_pd[i-1];
      end
      w_fi_n    = w_push ? ((r_fi == PMAX) ? '0 : r_fi + PW'(1)) : r_fi;
      w_fo_n    = w_fpop ? ((r_fo == PMAX) ? '0 : r_fo + PW'(1)) : r_fo;
      w_fcnt_n  = r_fcnt + OW'(w_push) - OW'(w_fpop);
      w_outst_n = r_outst + OW'(w_gnt) - OW'(w_pop);
      if (clear_i) begin
         w_lfsr_n  = LFSR_SEED;
         w_pv_n    = '0;
         for (int i = 0; i < LATENCY; i++) w_pd_n[i] = '0;
         w_fi_n    = '0;
         w_fo_n    = '0;
         w_fcnt_n  = '0;
         w_outst_n = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         r_lfsr  <= LFSR_SEED;
         r_pv    <= '0;
         for (int i = 0; i < LATENCY; i++) r_pd[i] <= '0;
         r_fi    <= '0;
         r_fo    <= '0;
         r_fcnt  <= '0;
         r_outst <= '0;
      end else begin
         r_lfsr  <= w_lfsr_n;
         r_pv    <= w_pv_n;
         r_pd    <= w_pd_n;
         r_fi    <= w_fi_n;
         r_fo    <= w_fo_n;
         r_fcnt  <= w_fcnt_n;
         r_outst <= w_outst_n;
      end

   // Storage is never reset: memory survives reset/clear, FIFO slots are gated by r_fcnt.
   always_ff @(posedge clk_i) begin
      if (w_push) r_fifo[r_fi] <= r_pd[LATENCY-1];
      if (w_gnt && !tcdm.wen)
         for (int b = 0; b < BW; b++)
            if (tcdm.be[b]) r_mem[w_idx][8*b +: 8] <= tcdm.data[8*b +: 8];
   end

   a_no_spurious_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
      tcdm.r_valid |-> r_outst != '0);
   a_no_fifo_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      w_push |-> r_fcnt < RD);
endmodule

// File: tb/tb_softex_tcdm_responder.sv
// tb_softex_tcdm_responder: random + directed stimulus, scoreboard queue checked by a
// free-running response monitor against a word-array memory model.
module tb_softex_tcdm_responder;
   logic        clk = 1'b0, rst_ni = 1'b0, clear = 1'b0, stall_en = 1'b0;
   logic [2:0]  outst;
   logic [1:0]  rdy_mode = 2'd1;
   logic        rnd_rdy = 1'b1;
   logic        done;
   int          n_chk = 0, n_err = 0, n_gnt = 0, n_stall = 0, cyc = 0, c0, g0;
   logic [31:0] mdl [1024];
   logic [40:0] q [$];

   softex_tcdm_responder_if bus ();

   softex_tcdm_responder dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .clear_i       (clear),
      .stall_en_i    (stall_en),
      .tcdm          (bus),
      .outstanding_o (outst)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign bus.r_ready = (rdy_mode == 2'd2) ? rnd_rdy : rdy_mode[0];

   initial forever begin
      @(posedge clk);
      #1 rnd_rdy = $urandom_range(0, 3) != 0;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk(input int w);
      logic [31:0] r;
      r = $urandom();
      return {r[31:12], w[9:0], r[1:0]};
   endfunction

   // Holds the request until granted; the model is updated and the response queued at grant.
   task automatic do_req(input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d, input logic [7:0] id);
      int n = 0;
      bit fin = 0;
      bus.add = a; bus.wen = w; bus.be = b; bus.data = d; bus.id = id; bus.req = 1'b1;
      while (!fin) begin
         @(negedge clk);
         if (bus.gnt) begin
            n_gnt++;
            if (w) q.push_back({1'b0, id, mdl[a[11:2]]});
            else begin
               for (int k = 0; k < 4; k++) if (b[k]) mdl[a[11:2]][8*k +: 8] = d[8*k +: 8];
               q.push_back({1'b1, id, 32'h0});
            end
            fin = 1;
         end else begin
            if (stall_en && outst < 3'd4) n_stall++;
            if (++n > 200) begin
               n_chk++; n_err++; fin = 1;
               $display("FAIL grant_timeout: got no gnt in 200 cycles, expected a grant for id %h", id);
            end
         end
         @(posedge clk);
         #1;
      end
      bus.req = 1'b0;
   endtask

   initial forever begin
      @(negedge clk);
      if (rst_ni && bus.r_valid) begin
         if (q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL unexpected_resp: got id %h, expected no response", bus.r_id);
         end else begin
            chk("resp", 64'({bus.r_opc, bus.r_id, bus.r_data}), 64'(q[0]));
            if (bus.r_ready) void'(q.pop_front());
         end
      end
   end

   initial begin
      bus.req = 0; bus.add = 0; bus.wen = 1; bus.be = 0; bus.data = 0; bus.id = 0;
      tick(3);
      rst_ni = 1'b1;
      chk("rst_gnt", 64'(bus.gnt), 0);
      chk("rst_valid", 64'(bus.r_valid), 0);
      chk("rst_rdata", 64'(bus.r_data), 0);
      chk("rst_rid", 64'(bus.r_id), 0);
      chk("rst_opc", 64'(bus.r_opc), 0);
      chk("rst_outst", 64'(outst), 0);

      do_req(32'h10, 1'b0, 4'hF, 32'hDEADBEEF, 8'd3);
      chk("t1_wr_ack", 64'({bus.r_valid, bus.r_opc, bus.r_id}), 64'({1'b1, 1'b1, 8'd3}));
      do_req(32'h10, 1'b1, 4'h0, 32'h0, 8'd4);
      chk("t1_rd_data", 64'({bus.r_valid, bus.r_opc, bus.r_id, bus.r_data}),
          64'({1'b1, 1'b0, 8'd4, 32'hDEADBEEF}));

      do_req(32'h20, 1'b0, 4'hF, 32'h11223344, 8'd5);
      do_req(32'h20, 1'b0, 4'b0101, 32'hAABBCCDD, 8'd6);
      do_req(32'h20, 1'b1, 4'h0, 32'h0, 8'd7);
      chk("t2_merge", 64'(bus.r_data), 64'(32'h11BB33DD));

      for (int i = 0; i < 64; i++) do_req(mk(i), 1'b0, 4'hF, $urandom(), 8'(i));

      c0 = cyc; g0 = n_gnt;
      for (int i = 0; i < 16; i++) do_req(32'(i * 4), 1'b1, 4'h0, 32'h0, 8'(8'h40 + i));
      chk("t4_cycles", 64'(cyc - c0), 16);
      chk("t4_grants", 64'(n_gnt - g0), 16);

      tick(3);
      rdy_mode = 2'd0; g0 = n_gnt; done = 1'b0;
      fork
         begin
            for (int i = 0; i < 5; i++) do_req(mk(i), 1'b1, 4'h0, 32'h0, 8'(8'h80 + i));
            done = 1'b1;
         end
      join_none
      tick(10);
      chk("t3_grants", 64'(n_gnt - g0), 4);
      chk("t3_gnt_low", 64'(bus.gnt), 0);
      chk("t3_outst", 64'(outst), 4);
      rdy_mode = 2'd1;
      tick(1);
      chk("t3_regrant", 64'(bus.gnt), 1);
      for (int k = 0; k < 100 && !done; k++) tick(1);
      chk("t3_done", 64'(done), 1);

      tick(5);
      stall_en = 1'b1; rdy_mode = 2'd2; n_stall = 0;
      for (int i = 0; i < 200; i++)
         do_req(mk(int'($urandom_range(0, 63))), 1'($urandom_range(0, 1)), 4'($urandom()),
                $urandom(), 8'($urandom()));
      stall_en = 1'b0; rdy_mode = 2'd1;
      chk("t5_stalls", 64'(n_stall > 0), 1);

      tick(5);
      rdy_mode = 2'd0;
      do_req(mk(50), 1'b0, 4'hF, 32'h5A5A0050, 8'd50);
      do_req(mk(51), 1'b0, 4'hF, 32'h5A5A0051, 8'd51);
      chk("clr_pre_outst", 64'(outst), 2);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      q.delete();
      chk("clr_valid", 64'(bus.r_valid), 0);
      chk("clr_outst", 64'(outst), 0);

      for (int i = 40; i < 43; i++) do_req(mk(i), 1'b0, 4'hF, 32'(32'hC0DE0000 + i), 8'(i));
      chk("t6_pre_outst", 64'(outst), 3);
      rst_ni = 1'b0;
      #1;
      chk("t6_valid", 64'(bus.r_valid), 0);
      chk("t6_outst", 64'(outst), 0);
      q.delete();
      #1 rst_ni = 1'b1;
      rdy_mode = 2'd1;
      for (int i = 40; i < 43; i++) do_req(mk(i), 1'b1, 4'h0, 32'h0, 8'(8'hA0 + i));
      do_req(mk(50), 1'b1, 4'h0, 32'h0, 8'hB0);
      do_req(mk(51), 1'b1, 4'h0, 32'h0, 8'hB1);

      for (int k = 0; k < 50 && q.size() > 0; k++) tick(1);
      chk("drain", 64'(q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
